// File: rtl/bit_serial_alu_seq_if.sv
// bit_serial_alu_seq_if: request/result and 1-bit ALU slice signals for bit_serial_alu_seq
//   slave  (sequencer): start/op/opa/opb/cin/slice_d/slice_e in; busy/done/result/cout/slice_a/b/c/ctr out
//   master (requester + slice): the reverse
//   ovf present only when BSALU_OVF_EN is defined
interface bit_serial_alu_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef BSALU_OVF_EN
  logic             ovf;
`endif
  logic             slice_a;
  logic             slice_b;
  logic             slice_c;
  logic [1:0]       slice_ctr;
  logic             slice_d;
  logic             slice_e;
  modport slave (
    input  start, op, opa, opb, cin, slice_d, slice_e,
`ifdef BSALU_OVF_EN
    output ovf,
`endif
    output busy, done, result, cout, slice_a, slice_b, slice_c, slice_ctr
  );
  modport master (
    output start, op, opa, opb, cin, slice_d, slice_e,
`ifdef BSALU_OVF_EN
    input  ovf,
`endif
    input  busy, done, result, cout, slice_a, slice_b, slice_c, slice_ctr
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: runs one WIDTH-bit ALU op LSB-first through an external 1-bit ALU slice
//   clk/rst: clock and synchronous active-high reset
//   bus (slave modport): start/op/opa/opb/cin request, busy/done/result/cout status,
//   slice_a/b/c/ctr drive and slice_d/e capture; BSALU_OVF_EN adds the signed-overflow output ovf
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  bit_serial_alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             add;
  logic             last;
  assign add  = op_q == 2'b00;
  assign last = cnt_q == CW'(WIDTH - 1);
  // slice is driven only while busy, so it sees all-zero inputs otherwise
  assign bus.slice_a   = busy_q & opa_q[cnt_q];
  assign bus.slice_b   = busy_q & opb_q[cnt_q];
  assign bus.slice_c   = busy_q & add & carry_q;
  assign bus.slice_ctr = busy_q ? op_q : 2'b00;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef BSALU_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
  // carry_q holds the carry into the MSB during the last RUN cycle
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (state_q == IDLE && bus.start) ovf_q <= 1'b0;
    else if (state_q == RUN && last) ovf_q <= add & (carry_q ^ bus.slice_e);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          opa_q    <= bus.opa;
          opb_q    <= bus.opb;
          op_q     <= bus.op;
          carry_q  <= bus.cin;
          cnt_q    <= '0;
          result_q <= '0;
          cout_q   <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= RUN;
        end
        RUN: begin
          result_q[cnt_q] <= bus.slice_d;
          carry_q         <= add & bus.slice_e;
          cnt_q           <= cnt_q + CW'(1);
          if (last) begin
            cout_q  <= add & bus.slice_e;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
